// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the output writeback slice
package wb_pkg;
  localparam int LANES = 16;
  localparam int ACC_W = 32;
  localparam int ADDR_W = 13;
  localparam int SHARE_W = 128;
  localparam int ROW_W = 6;
  localparam int SH_W = 5;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-128);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;
  typedef struct packed {
    logic [ROW_W-1:0]  nrows;
    logic [ADDR_W-1:0] oaddr;
    logic [SH_W-1:0]   oshift;
    logic              relu;
  } cfg_t;
endpackage

// File: rtl/output_writeback_if.sv
// output_writeback_if: control, output-buffer read and shared-SRAM write signals; master = writeback engine
interface output_writeback_if;
  import wb_pkg::*;
  logic                   start, relu, busy, done;
  logic [ROW_W-1:0]       nrows;
  logic [ADDR_W-1:0]      oaddr;
  logic [SH_W-1:0]        oshift;
  logic                   output_cen, output_ren;
  logic [ADDR_W-1:0]      output_addr;
  logic [LANES*ACC_W-1:0] output_rdata;
  logic                   share_req, share_gnt, share_cen, share_wen;
  logic [ADDR_W-1:0]      share_addr;
  logic [SHARE_W-1:0]     share_wdata;
  modport master (
    input  start, nrows, oaddr, oshift, relu, output_rdata, share_gnt,
    output busy, done, output_cen, output_ren, output_addr,
           share_req, share_cen, share_wen, share_addr, share_wdata
  );
  modport slave (
    output start, nrows, oaddr, oshift, relu, output_rdata, share_gnt,
    input  busy, done, output_cen, output_ren, output_addr,
           share_req, share_cen, share_wen, share_addr, share_wdata
  );
endinterface

// File: rtl/output_writeback_quant.sv
// quant_lane: one accumulator lane -> rounded arithmetic shift, optional ReLU, int8 saturation (acc_i, shift_i, relu_i -> q_o)
module quant_lane
  import wb_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [SH_W-1:0]  shift_i,
  input  logic             relu_i,
  output logic [7:0]       q_o
);
  logic signed [ACC_W:0] rnd, v, r;
  always_comb begin
    rnd = shift_i == '0 ? '0 : (ACC_W+1)'(1) << (shift_i - SH_W'(1));
    v = $signed({acc_i[ACC_W-1], acc_i}) + rnd;
    r = v >>> shift_i;
    r = relu_i && r[ACC_W] ? '0 : r;
    q_o = r > SAT_MAX ? 8'h7f : r < SAT_MIN ? 8'h80 : r[7:0];
  end
endmodule

// File: rtl/output_writeback.sv
// output_writeback: drains accumulator rows (clk, rst, bus: start/params, output-buffer read, shared-SRAM write) into int8 rows
module output_writeback
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output_writeback_if.master  bus
);
  state_e             state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [ROW_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic               inflight_q, head_q, head_d;
  logic [1:0]         count_q, count_d;
  logic [SHARE_W-1:0] mem_q [2];
  logic [SHARE_W-1:0] q_row;
  logic               launch, pop, issue;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    quant_lane u_q (
      .acc_i   (bus.output_rdata[i*ACC_W +: ACC_W]),
      .shift_i (cfg_q.oshift),
      .relu_i  (cfg_q.relu),
      .q_o     (q_row[i*8 +: 8])
    );
  end
  // a read is only issued when its row is guaranteed a FIFO slot on return
  always_comb begin
    launch = state_q == IDLE && bus.start;
    pop = count_q != '0 && bus.share_gnt;
    issue = state_q == RUN && 3'(count_q) + 3'(inflight_q) - 3'(pop) < 3'd2;
    count_d = count_q + 2'(inflight_q) - 2'(pop);
    head_d = head_q ^ pop;
    cfg_d = launch ? '{bus.nrows, bus.oaddr, bus.oshift, bus.relu} : cfg_q;
    rd_ptr_d = launch ? '0 : rd_ptr_q + ROW_W'(issue);
    wr_ptr_d = launch ? '0 : wr_ptr_q + ROW_W'(pop);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !bus.start ? IDLE : bus.nrows == '0 ? FIN : RUN;
      RUN:     state_d = issue && rd_ptr_q == cfg_q.nrows - ROW_W'(1) ? DRAIN : RUN;
      DRAIN:   state_d = count_d == '0 ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      inflight_q <= 1'b0;
      count_q <= '0;
      head_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      inflight_q <= issue;
      count_q <= count_d;
      head_q <= head_d;
      if (inflight_q) mem_q[head_q ^ count_q[0]] <= q_row;
    end
  end
  assign bus.busy = state_q == RUN || state_q == DRAIN;
  assign bus.done = state_q == FIN;
  assign bus.output_ren = issue;
  assign bus.output_cen = issue;
  assign bus.output_addr = issue ? ADDR_W'(rd_ptr_q) : '0;
  assign bus.share_req = count_q != '0;
  assign bus.share_cen = bus.share_req;
  assign bus.share_wen = !bus.share_req;
  assign bus.share_addr = bus.share_req ? cfg_q.oaddr + ADDR_W'(wr_ptr_q) : '0;
  assign bus.share_wdata = bus.share_req ? mem_q[head_q] : '0;
endmodule

// File: tb/tb_output_writeback.sv
// tb_output_writeback: randomized scenarios for output_writeback against an arithmetic row model
module tb_output_writeback;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  output_writeback_if bus();
  output_writeback dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, fails = 0, cyc = 0;
  logic [511:0] rows [32];
  logic [12:0]  wq_addr[$];
  logic [127:0] wq_data[$];
  int           wq_cyc[$];
  int n_rd, max_out, done_cnt, done_cyc, start_cyc, stall_bad, proto_bad = 0;
  bit rd_v = 0, stall_prev = 0, busy1, busy_done;
  logic [4:0]   rd_a;
  logic [12:0]  st_addr;
  logic [127:0] st_data;

  function automatic logic [127:0] exp_row(input logic [511:0] r, input int sh, input bit rl);
    logic [127:0] e;
    longint v;
    for (int l = 0; l < 16; l++) begin
      v = longint'($signed(r[l*32 +: 32]));
      if (sh > 0) v += longint'(1) << (sh - 1);
      v = v >>> sh;
      if (rl && v < 0) v = 0;
      v = v > 127 ? 127 : v < -128 ? -128 : v;
      e[l*8 +: 8] = 8'(v);
    end
    return e;
  endfunction

  function automatic bit gnt_for(input int gm, input int k);
    if (gm == 1) return k < 8 ? k % 2 == 0 : k < 18 ? 1'b0 : k % 2 == 0;
    if (gm == 2) return $urandom_range(0, 2) != 0;
    return 1'b1;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < 32; r++)
      for (int l = 0; l < 16; l++)
        case (mode)
          0: rows[r][l*32 +: 32] = 32'd5;
          1: case (l % 4) 0: rows[r][l*32 +: 32] = 32'd24; 1: rows[r][l*32 +: 32] = -32'sd24;
                          2: rows[r][l*32 +: 32] = 32'd8; default: rows[r][l*32 +: 32] = 32'd7; endcase
          2: case (l % 4) 0: rows[r][l*32 +: 32] = 32'h7FFFFFFF; 1: rows[r][l*32 +: 32] = 32'h80000000;
                          2: rows[r][l*32 +: 32] = 32'hFFFFFFFF; default: rows[r][l*32 +: 32] = 32'h0; endcase
          default: rows[r][l*32 +: 32] = $urandom_range(0, 3) == 0 ? $urandom() : 32'($signed($urandom_range(0, 8191)) - 4096);
        endcase
  endtask

  // one clock: present read data, sample outputs, advance to posedge+1
  task automatic step();
    if (rd_v) bus.output_rdata = rows[rd_a];
    else for (int l = 0; l < 16; l++) bus.output_rdata[l*32 +: 32] = $urandom();
    #1;
    rd_v = bus.output_ren;
    rd_a = bus.output_addr[4:0];
    if (bus.output_ren) n_rd++;
    if (bus.share_cen !== bus.share_req || bus.share_wen !== !bus.share_req || bus.output_cen !== bus.output_ren) proto_bad++;
    if (stall_prev && !(bus.share_req && bus.share_addr == st_addr && bus.share_wdata == st_data)) stall_bad++;
    stall_prev = bus.share_req && !bus.share_gnt;
    st_addr = bus.share_addr;
    st_data = bus.share_wdata;
    if (bus.share_req && bus.share_gnt) begin
      wq_addr.push_back(bus.share_addr);
      wq_data.push_back(bus.share_wdata);
      wq_cyc.push_back(cyc);
    end
    if (n_rd - wq_addr.size() > max_out) max_out = n_rd - wq_addr.size();
    if (bus.done) begin done_cnt++; done_cyc = cyc; busy_done = bus.busy; end
    if (cyc == start_cyc + 1) busy1 = bus.busy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input int oa, input int sh, input bit rl, input int gm, input int mid);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    n_rd = 0; max_out = 0; done_cnt = 0; done_cyc = -1; stall_bad = 0; stall_prev = 0;
    bus.nrows = 6'(n); bus.oaddr = 13'(oa); bus.oshift = 5'(sh); bus.relu = rl;
    bus.start = 1; start_cyc = cyc; bus.share_gnt = gnt_for(gm, 0);
    step();
    bus.start = 0;
    for (int k = 1; k < 400 && done_cnt == 0; k++) begin
      bus.nrows = 6'($urandom()); bus.oaddr = 13'($urandom()); bus.oshift = 5'($urandom());
      bus.share_gnt = gnt_for(gm, k);
      if (k == mid) begin bus.start = 1; bus.nrows = 6'd2; bus.oaddr = 13'h55; bus.relu = !rl; end
      step();
      bus.start = 0;
    end
    for (int k = 0; k < 3; k++) begin bus.share_gnt = 1; step(); end
  endtask

  task automatic test_reset();
    rst = 1; bus.start = 0; bus.share_gnt = 0; bus.nrows = 0; bus.oaddr = 0; bus.oshift = 0; bus.relu = 0;
    bus.output_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if ({bus.output_cen, bus.output_ren} !== 2'b00) begin fails++; $display("FAIL reset_ocen_oren got %b want 00", {bus.output_cen, bus.output_ren}); end
    checks++; if (bus.output_addr !== 0) begin fails++; $display("FAIL reset_oaddr got %h want 0", bus.output_addr); end
    checks++; if ({bus.share_req, bus.share_cen, bus.share_wen} !== 3'b001) begin fails++; $display("FAIL reset_share_ctl got %b want 001", {bus.share_req, bus.share_cen, bus.share_wen}); end
    checks++; if (bus.share_addr !== 0 || bus.share_wdata !== 0) begin fails++; $display("FAIL reset_share_bus got %h/%h want 0/0", bus.share_addr, bus.share_wdata); end
    rst = 0;
  endtask

  task automatic test_stream(input string nm, input int n, input int oa, input int sh, input bit rl, input int gm);
    run(n, oa, sh, rl, gm, -1);
    checks++; if (wq_addr.size() != n) begin fails++; $display("FAIL %s_count got %0d want %0d", nm, wq_addr.size(), n); end
    for (int i = 0; i < wq_addr.size() && i < n; i++) begin
      checks++; if (wq_addr[i] !== 13'(oa + i)) begin fails++; $display("FAIL %s_addr[%0d] got %h want %h", nm, i, wq_addr[i], 13'(oa + i)); end
      checks++; if (wq_data[i] !== exp_row(rows[i], sh, rl)) begin fails++; $display("FAIL %s_data[%0d] got %h want %h", nm, i, wq_data[i], exp_row(rows[i], sh, rl)); end
    end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL %s_done_count got %0d want 1", nm, done_cnt); end
    if (wq_cyc.size() > 0) begin
      checks++; if (done_cyc != wq_cyc[$] + 1) begin fails++; $display("FAIL %s_done_cycle got %0d want %0d", nm, done_cyc, wq_cyc[$] + 1); end
    end
    checks++; if (max_out > 2) begin fails++; $display("FAIL %s_outstanding got %0d want <=2", nm, max_out); end
    checks++; if (stall_bad != 0) begin fails++; $display("FAIL %s_stall_stable got %0d want 0", nm, stall_bad); end
  endtask

  task automatic test_basic();
    fill(0);
    test_stream("basic", 4, 'h100, 0, 0, 0);
    checks++; if (wq_cyc.size() == 0 || wq_cyc[0] != start_cyc + 3) begin fails++; $display("FAIL basic_first_write got %0d want %0d", wq_cyc.size() ? wq_cyc[0] - start_cyc : -1, 3); end
    checks++; if (wq_data.size() == 0 || wq_data[0] !== {16{8'h05}}) begin fails++; $display("FAIL basic_bytes got %h want all 05", wq_data.size() ? wq_data[0] : '0); end
    checks++; if (busy1 !== 1 || busy_done !== 0) begin fails++; $display("FAIL basic_busy got %b%b want 10", busy1, busy_done); end
  endtask

  task automatic test_round();
    fill(1);
    test_stream("round", 3, 'h020, 4, 0, 0);
    checks++; if (wq_data.size() == 0 || wq_data[0][31:0] !== 32'h0001FF02) begin fails++; $display("FAIL round_lanes got %h want 0001ff02", wq_data.size() ? wq_data[0][31:0] : '0); end
    test_stream("round_relu", 3, 'h020, 4, 1, 0);
    checks++; if (wq_data.size() == 0 || wq_data[0][31:0] !== 32'h00010002) begin fails++; $display("FAIL relu_lanes got %h want 00010002", wq_data.size() ? wq_data[0][31:0] : '0); end
  endtask

  task automatic test_saturate();
    fill(2);
    test_stream("sat0", 2, 'h300, 0, 0, 0);
    checks++; if (wq_data.size() == 0 || wq_data[0][31:0] !== 32'h00FF807F) begin fails++; $display("FAIL sat0_lanes got %h want 00ff807f", wq_data.size() ? wq_data[0][31:0] : '0); end
    test_stream("sat31", 2, 'h300, 31, 0, 0);
    checks++; if (wq_data.size() == 0 || wq_data[0][31:0] !== 32'h0000FF01) begin fails++; $display("FAIL sat31_lanes got %h want 0000ff01", wq_data.size() ? wq_data[0][31:0] : '0); end
  endtask

  task automatic test_stall();
    fill(3);
    test_stream("stall", 8, 'h040, $urandom_range(0, 31), 1'($urandom()), 1);
  endtask

  task automatic test_wrap();
    fill(3);
    test_stream("wrap", 4, 'h1FFE, $urandom_range(0, 12), 1'($urandom()), 2);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      fill(3);
      test_stream("rand", $urandom_range(1, 32), $urandom_range(0, 8191), $urandom_range(0, 31), 1'($urandom()), 2);
    end
    checks++; if (proto_bad != 0) begin fails++; $display("FAIL enables_consistent got %0d bad cycles want 0", proto_bad); end
  endtask

  task automatic test_zero();
    run(0, 'h123, 0, 0, 0, -1);
    checks++; if (done_cyc != start_cyc + 1 || done_cnt != 1) begin fails++; $display("FAIL zero_done got cycle %0d count %0d want %0d/1", done_cyc - start_cyc, done_cnt, 1); end
    checks++; if (n_rd != 0 || wq_addr.size() != 0) begin fails++; $display("FAIL zero_access got %0d reads %0d writes want 0/0", n_rd, wq_addr.size()); end
  endtask

  task automatic test_start_ignored();
    fill(3);
    run(6, 'h0A0, 3, 0, 0, 3);
    checks++; if (wq_addr.size() != 6 || done_cnt != 1) begin fails++; $display("FAIL restart_count got %0d writes %0d done want 6/1", wq_addr.size(), done_cnt); end
    for (int i = 0; i < wq_addr.size() && i < 6; i++) begin
      checks++; if (wq_addr[i] !== 13'('h0A0 + i) || wq_data[i] !== exp_row(rows[i], 3, 0)) begin fails++; $display("FAIL restart_row[%0d] got %h/%h want %h/%h", i, wq_addr[i], wq_data[i], 13'('h0A0 + i), exp_row(rows[i], 3, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    fill(3);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); n_rd = 0; done_cnt = 0;
    bus.nrows = 8; bus.oaddr = 'h200; bus.oshift = 2; bus.relu = 0; bus.start = 1; bus.share_gnt = 1; start_cyc = cyc;
    step();
    bus.start = 0;
    for (int k = 0; k < 50 && wq_addr.size() < 3; k++) step();
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++; if (bus.busy !== 0 || bus.done !== 0) begin fails++; $display("FAIL rstmid_busy_done got %b%b want 00", bus.busy, bus.done); end
    checks++; if ({bus.output_cen, bus.output_ren} !== 2'b00 || bus.output_addr !== 0) begin fails++; $display("FAIL rstmid_read got %b/%h want 00/0", {bus.output_cen, bus.output_ren}, bus.output_addr); end
    checks++; if ({bus.share_req, bus.share_cen, bus.share_wen} !== 3'b001 || bus.share_addr !== 0 || bus.share_wdata !== 0) begin fails++; $display("FAIL rstmid_share got %b/%h/%h want 001/0/0", {bus.share_req, bus.share_cen, bus.share_wen}, bus.share_addr, bus.share_wdata); end
    w = wq_addr.size();
    done_cnt = 0;
    repeat (20) step();
    checks++; if (done_cnt != 0 || wq_addr.size() != w) begin fails++; $display("FAIL rstmid_quiet got %0d done %0d extra writes want 0/0", done_cnt, wq_addr.size() - w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_stall();
    test_wrap();
    test_random();
    test_zero();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
